bus_arbiter_mux: RTL and testbench

//  Parametrised N-master bus arbiter plus master-side mux for the shared dcpu bus.

---
 rtl/bus_arbiter_mux_if.sv | 29 ++
 rtl/bus_arbiter_mux.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_mux_if.sv
// Shared dcpu bus bundle between NUM_M masters and the arbiter/mux.
// The master modport is the masters' view; the slave modport is the arbiter's view.
interface bus_arbiter_mux_if #(
    parameter int NUM_M = 4,
    parameter int AW    = 30,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]    m_req;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M-1:0]    m_as;
    logic [NUM_M-1:0]    m_rw;
    logic [NUM_M*DW-1:0] m_wr_data;
    logic [NUM_M-1:0]    m_grnt;
    logic [AW-1:0]       s_addr;
    logic                s_as;
    logic                s_rw;
    logic [DW-1:0]       s_wr_data;
    logic                arb_timeout;

    modport master (
        output m_req, m_addr, m_as, m_rw, m_wr_data,
        input  m_grnt, s_addr, s_as, s_rw, s_wr_data, arb_timeout
    );

    modport slave (
        input  m_req, m_addr, m_as, m_rw, m_wr_data,
        output m_grnt, s_addr, s_as, s_rw, s_wr_data, arb_timeout
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// N-master bus arbiter (fixed-priority or round-robin, grant held while owner requests) plus shared-bus mux.
// Define BUS_ARB_TIMEOUT_EN to force an owner off after MAX_HOLD cycles when another master waits.
module bus_arbiter_mux #(
    parameter int NUM_M    = 4,
    parameter int AW       = 30,
    parameter int DW       = 32,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_mux_if.slave bus
);
    localparam int          IW       = $clog2(NUM_M);
    localparam logic [IW:0] NUM_WIDE = (IW+1)'(NUM_M);
    // dcpu encodings: `READ = 1, `WRITE = 0, `NO = 0
    localparam logic READ = 1'b1;
    localparam logic NO   = 1'b0;

    typedef enum logic {IDLE, OWN} state_e;

    state_e             state_q;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      rrPtr_q;
    logic [NUM_M-1:0]   grnt_q;

    logic [NUM_M-1:0]   searchMask;
    logic [2*NUM_M-1:0] maskTwice;
    logic [NUM_M-1:0]   maskRot;
    logic [IW-1:0]      searchStart;
    logic [IW-1:0]      offset;
    logic [IW:0]        winnerSum;
    logic [IW-1:0]      winnerIdx;
    logic [IW:0]        ptrSum;
    logic [IW-1:0]      nextPtr;
    logic               winnerValid;
    logic               grantNow;
    logic               releaseNow;

    logic [AW-1:0]      sAddr;
    logic               sAs;
    logic               sRw;
    logic [DW-1:0]      sWrData;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int            CW        = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    logic [CW-1:0]            holdCnt_q;
    logic                     arbTimeout_q;
    logic                     forceNow;
`endif

    // Rotate the request mask so the search start sits at bit 0, then take the lowest set bit.
    always_comb begin
        searchMask = bus.m_req;
        if (state_q == OWN) begin
            searchMask[owner_q] = 1'b0;
        end
        searchStart = (RR_MODE != 0) ? rrPtr_q : '0;
        maskTwice   = {searchMask, searchMask} >> searchStart;
        maskRot     = maskTwice[NUM_M-1:0];
        winnerValid = |maskRot;
        offset      = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (maskRot[i]) begin
                offset = IW'(i);
            end
        end
        winnerSum = {1'b0, searchStart} + {1'b0, offset};
        winnerIdx = (winnerSum >= NUM_WIDE) ? IW'(winnerSum - NUM_WIDE) : winnerSum[IW-1:0];
        ptrSum    = {1'b0, winnerIdx} + (IW+1)'(1);
        nextPtr   = (ptrSum >= NUM_WIDE) ? '0 : ptrSum[IW-1:0];
    end

    always_comb begin
        grantNow   = 1'b0;
        releaseNow = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        forceNow   = 1'b0;
`endif
        if (state_q == IDLE) begin
            grantNow = winnerValid;
        end else if (!bus.m_req[owner_q]) begin
            grantNow   = winnerValid;
            releaseNow = !winnerValid;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (holdCnt_q == HOLD_LAST && winnerValid) begin
            grantNow = 1'b1;
            forceNow = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rrPtr_q <= '0;
            grnt_q  <= '0;
        end else if (grantNow) begin
            state_q <= OWN;
            owner_q <= winnerIdx;
            rrPtr_q <= nextPtr;
            grnt_q  <= NUM_M'(1) << winnerIdx;
        end else if (releaseNow) begin
            state_q <= IDLE;
            grnt_q  <= '0;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Counts owned cycles of the current owner; saturates when nobody else is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            holdCnt_q    <= '0;
            arbTimeout_q <= 1'b0;
        end else begin
            arbTimeout_q <= forceNow;
            if (grantNow) begin
                holdCnt_q <= '0;
            end else if (state_q == OWN && holdCnt_q != HOLD_LAST) begin
                holdCnt_q <= holdCnt_q + CW'(1);
            end
        end
    end

    assign bus.arb_timeout = arbTimeout_q;
`else
    assign bus.arb_timeout = 1'b0;
`endif

    // The one-hot grant register alone selects the master; a zero grant leaves idle values.
    always_comb begin
        sAddr   = '0;
        sAs     = NO;
        sRw     = READ;
        sWrData = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grnt_q[i]) begin
                sAddr   = bus.m_addr[i*AW +: AW];
                sAs     = bus.m_as[i];
                sRw     = bus.m_rw[i];
                sWrData = bus.m_wr_data[i*DW +: DW];
            end
        end
    end

    assign bus.m_grnt    = grnt_q;
    assign bus.s_addr    = sAddr;
    assign bus.s_as      = sAs;
    assign bus.s_rw      = sRw;
    assign bus.s_wr_data = sWrData;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: a round-robin and a fixed-priority instance share one stimulus stream
// and are checked against vector tables, directed sequences and a queue-free behavioural model.
module tb_bus_arbiter_mux;
    localparam int   NUM_M    = 4;
    localparam int   AW       = 30;
    localparam int   DW       = 32;
    localparam int   MAX_HOLD = 16;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit   TIMEOUT_ON = 1'b1;
`else
    localparam bit   TIMEOUT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NUM_M-1:0]    req;
    logic [NUM_M-1:0]    as;
    logic [NUM_M-1:0]    rw;
    logic [AW-1:0]       addr [NUM_M];
    logic [DW-1:0]       wdata[NUM_M];
    logic [NUM_M*AW-1:0] addrBus;
    logic [NUM_M*DW-1:0] dataBus;

    int nCompared   = 0;
    int nMismatched = 0;

    int mdlOwner[2];
    int mdlStart[2];
    int mdlOwned[2];
    bit mdlTmo[2];

    bus_arbiter_mux_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) ifRr();
    bus_arbiter_mux_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) ifFp();

    bus_arbiter_mux #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .RR_MODE(1), .MAX_HOLD(MAX_HOLD)) dutRr (
        .clk(clk), .reset(reset), .bus(ifRr)
    );
    bus_arbiter_mux #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .RR_MODE(0), .MAX_HOLD(MAX_HOLD)) dutFp (
        .clk(clk), .reset(reset), .bus(ifFp)
    );

    always_comb begin
        addrBus = '0;
        dataBus = '0;
        for (int i = 0; i < NUM_M; i++) begin
            addrBus[i*AW +: AW] = addr[i];
            dataBus[i*DW +: DW] = wdata[i];
        end
    end

    assign ifRr.m_req = req;  assign ifRr.m_as = as;  assign ifRr.m_rw = rw;
    assign ifRr.m_addr = addrBus;  assign ifRr.m_wr_data = dataBus;
    assign ifFp.m_req = req;  assign ifFp.m_as = as;  assign ifFp.m_rw = rw;
    assign ifFp.m_addr = addrBus;  assign ifFp.m_wr_data = dataBus;

    typedef struct {
        bit               resetBefore;
        bit               useFp;
        logic [NUM_M-1:0] req;
        logic [NUM_M-1:0] expGrnt;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_M-1:0] newReq, input logic [NUM_M-1:0] newAs,
                                 input logic [NUM_M-1:0] newRw);
        req = newReq;
        as  = newAs;
        rw  = newRw;
    endtask

    task automatic readDut(input int d, output logic [NUM_M-1:0] g, output logic [AW-1:0] a,
                           output logic s, output logic w, output logic [DW-1:0] dat, output logic t);
        if (d == 0) begin
            g = ifRr.m_grnt; a = ifRr.s_addr; s = ifRr.s_as; w = ifRr.s_rw; dat = ifRr.s_wr_data; t = ifRr.arb_timeout;
        end else begin
            g = ifFp.m_grnt; a = ifFp.s_addr; s = ifFp.s_as; w = ifFp.s_rw; dat = ifFp.s_wr_data; t = ifFp.arb_timeout;
        end
    endtask

    // Round-robin searches from the slot after the last new owner; fixed priority always from 0.
    function automatic int pickWinner(input int d, input int exclude);
        int start = (d == 0) ? mdlStart[d] : 0;
        for (int n = 0; n < NUM_M; n++) begin
            int c = (start + n) % NUM_M;
            if (c != exclude && req[c]) return c;
        end
        return -1;
    endfunction

    task automatic giveBus(input int d, input int w);
        mdlOwner[d] = w;
        mdlStart[d] = (w + 1) % NUM_M;
        mdlOwned[d] = 1;
    endtask

    task automatic modelStep();
        for (int d = 0; d < 2; d++) begin
            int w;
            mdlTmo[d] = 1'b0;
            if (reset) begin
                mdlOwner[d] = -1;
                mdlStart[d] = 0;
                mdlOwned[d] = 0;
            end else if (mdlOwner[d] < 0 || !req[mdlOwner[d]]) begin
                w = pickWinner(d, mdlOwner[d]);
                if (w >= 0) giveBus(d, w);
                else mdlOwner[d] = -1;
            end else begin
                w = pickWinner(d, mdlOwner[d]);
                if (TIMEOUT_ON && mdlOwned[d] >= MAX_HOLD && w >= 0) begin
                    giveBus(d, w);
                    mdlTmo[d] = 1'b1;
                end else begin
                    mdlOwned[d]++;
                end
            end
        end
    endtask

    task automatic checkAgainstModel();
        for (int d = 0; d < 2; d++) begin
            logic [NUM_M-1:0] g;
            logic [AW-1:0]    a;
            logic             s, w, t;
            logic [DW-1:0]    dat;
            int               o = mdlOwner[d];
            string            tag = (d == 0) ? "rr" : "fp";
            readDut(d, g, a, s, w, dat, t);
            checkOutput({tag, ".grnt"},    g,   (o >= 0) ? (64'd1 << o) : 64'd0);
            checkOutput({tag, ".s_addr"},  a,   (o >= 0) ? addr[o] : '0);
            checkOutput({tag, ".s_as"},    s,   (o >= 0) ? as[o] : 1'b0);
            checkOutput({tag, ".s_rw"},    w,   (o >= 0) ? rw[o] : READ);
            checkOutput({tag, ".s_wdata"}, dat, (o >= 0) ? wdata[o] : '0);
            checkOutput({tag, ".timeout"}, t,   mdlTmo[d]);
            checkOutput({tag, ".onehot"},  $countones(g) <= 1, 1);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
        checkAgainstModel();
    endtask

    task automatic resetCycle();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM_M-1:0] g;
        logic [AW-1:0]    a;
        logic             s, w, t;
        logic [DW-1:0]    dat;

        for (int d = 0; d < 2; d++) begin
            mdlOwner[d] = -1; mdlStart[d] = 0; mdlOwned[d] = 0; mdlTmo[d] = 1'b0;
        end
        for (int i = 0; i < NUM_M; i++) begin
            addr[i]  = AW'(32'h0100_0000 + i * 32'h11);
            wdata[i] = 32'hA000_0000 + DW'(i);
        end
        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b1111);

        vecs[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0001};
        vecs[1]  = '{1'b0, 1'b0, 4'b1110, 4'b0010};
        vecs[2]  = '{1'b0, 1'b0, 4'b1101, 4'b0100};
        vecs[3]  = '{1'b0, 1'b0, 4'b1011, 4'b1000};
        vecs[4]  = '{1'b0, 1'b0, 4'b0111, 4'b0001};
        vecs[5]  = '{1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b0, 1'b0, 4'b0011, 4'b0010};
        vecs[7]  = '{1'b1, 1'b1, 4'b1110, 4'b0010};
        vecs[8]  = '{1'b0, 1'b1, 4'b1110, 4'b0010};
        vecs[9]  = '{1'b0, 1'b1, 4'b1010, 4'b0010};
        vecs[10] = '{1'b0, 1'b1, 4'b1000, 4'b1000};
        vecs[11] = '{1'b0, 1'b1, 4'b1100, 4'b1000};
        vecs[12] = '{1'b0, 1'b1, 4'b0100, 4'b0100};
        vecs[13] = '{1'b0, 1'b1, 4'b0000, 4'b0000};

        stepCycle();
        stepCycle();
        for (int d = 0; d < 2; d++) begin
            readDut(d, g, a, s, w, dat, t);
            checkOutput("reset.grnt", g, 0);
            checkOutput("reset.s_addr", a, 0);
            checkOutput("reset.s_as", s, 0);
            checkOutput("reset.s_rw", w, READ);
            checkOutput("reset.timeout", t, 0);
        end
        reset = 1'b0;

        $display("[TB] single master request, write and release");
        applyStimulus(4'b0001, 4'b0000, 4'b1111);
        #1;
        checkOutput("latency.noGrantYet", ifRr.m_grnt, 4'b0000);
        stepCycle();
        checkOutput("single.grnt", ifRr.m_grnt, 4'b0001);
        checkOutput("single.s_addr", ifRr.s_addr, addr[0]);
        applyStimulus(4'b0001, 4'b0001, 4'b1110);
        #1;
        checkOutput("single.s_as", ifRr.s_as, 1'b1);
        checkOutput("single.s_rw", ifRr.s_rw, WRITE);
        checkOutput("single.s_wdata", ifRr.s_wr_data, wdata[0]);
        applyStimulus(4'b0000, 4'b0001, 4'b1110);
        #1;
        checkOutput("release.grntHeld", ifRr.m_grnt, 4'b0001);
        stepCycle();
        checkOutput("release.grnt", ifRr.m_grnt, 4'b0000);
        checkOutput("release.s_addr", ifRr.s_addr, 0);
        checkOutput("release.s_as", ifRr.s_as, 1'b0);
        checkOutput("release.s_rw", ifRr.s_rw, READ);

        $display("[TB] vector table");
        applyStimulus(4'b0000, 4'b0000, 4'b1111);
        for (int v = 0; v < 14; v++) begin
            if (vecs[v].resetBefore) resetCycle();
            applyStimulus(vecs[v].req, 4'b0000, 4'b1111);
            stepCycle();
            readDut(vecs[v].useFp ? 1 : 0, g, a, s, w, dat, t);
            checkOutput($sformatf("vec%0d.grnt", v), g, vecs[v].expGrnt);
            for (int i = 0; i < NUM_M; i++) begin
                if (vecs[v].expGrnt[i]) checkOutput($sformatf("vec%0d.s_addr", v), a, addr[i]);
            end
        end

        $display("[TB] long hold by master 2 with master 0 waiting");
        resetCycle();
        applyStimulus(4'b0100, 4'b0000, 4'b1111);
        stepCycle();
        checkOutput("hold.first", ifRr.m_grnt, 4'b0100);
        applyStimulus(4'b0101, 4'b0000, 4'b1111);
        for (int e = 1; e <= 40; e++) begin
            logic [NUM_M-1:0] expG;
            logic             expT;
            stepCycle();
            if (!TIMEOUT_ON) begin
                expG = 4'b0100;
                expT = 1'b0;
            end else begin
                expG = (e >= MAX_HOLD && e < 2 * MAX_HOLD) ? 4'b0001 : 4'b0100;
                expT = (e == MAX_HOLD || e == 2 * MAX_HOLD);
            end
            checkOutput($sformatf("hold%0d.rr.grnt", e), ifRr.m_grnt, expG);
            checkOutput($sformatf("hold%0d.fp.grnt", e), ifFp.m_grnt, expG);
            checkOutput($sformatf("hold%0d.timeout", e), ifRr.arb_timeout, expT);
        end

        $display("[TB] reset during a write by master 3");
        resetCycle();
        applyStimulus(4'b1000, 4'b0000, 4'b1111);
        stepCycle();
        applyStimulus(4'b1000, 4'b1000, 4'b0111);
        #1;
        checkOutput("midwrite.s_as", ifRr.s_as, 1'b1);
        checkOutput("midwrite.s_rw", ifRr.s_rw, WRITE);
        reset = 1'b1;
        stepCycle();
        for (int d = 0; d < 2; d++) begin
            readDut(d, g, a, s, w, dat, t);
            checkOutput("abort.grnt", g, 0);
            checkOutput("abort.s_as", s, 0);
            checkOutput("abort.s_addr", a, 0);
            checkOutput("abort.s_rw", w, READ);
        end
        reset = 1'b0;

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            logic [NUM_M-1:0] flip;
            flip = NUM_M'($urandom) & NUM_M'($urandom) & NUM_M'($urandom);
            applyStimulus(req ^ flip, NUM_M'($urandom), NUM_M'($urandom));
            for (int i = 0; i < NUM_M; i++) begin
                addr[i]  = AW'($urandom);
                wdata[i] = $urandom;
            end
            reset = ($urandom_range(0, 59) == 0);
            stepCycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
